ddr4_ref_responder: RTL and testbench

// DIMM-side responder for the DDR4 command bus. Decodes cs_n/act_n/A[16:14] each ck_t edge, tracks per-bank state
// (IDLE/ACTIVE/REFRESHING), and times per-bank and all-bank REF for TRFC cycles. Reports refresh completion and

---
 rtl/ddr4_cmd_pkg.sv | 40 ++++
 rtl/ddr4_bank_ref_fsm.sv | 94 +++++++++
 rtl/ddr4_ref_responder.sv | 99 +++++++++
 tb/tb_ddr4_ref_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_cmd_pkg.sv
// Shared types for the DDR4 refresh responder: decoded commands, bank states, violation codes
// and the command-bus decode.
package ddr4_cmd_pkg;

  typedef enum logic [3:0] {
    DES, NOP, ACT, PRE, RD, WR, REF, MRS, ZQ, RSV
  } ddr4_cmd_t;

  typedef enum logic [1:0] {
    StIdle, StActive, StRefreshing
  } bank_state_t;

  typedef enum logic [2:0] {
    V_NONE, V_REF_OPEN, V_REF_BUSY, V_NOT_OPEN, V_ACT_OPEN, V_RSV
  } ddr4_viol_t;

  // rcw = {RAS_n, CAS_n, WE_n} = A[16:14]; only meaningful when act_n = 1
  function automatic ddr4_cmd_t decode_cmd(input logic cs_n, input logic act_n,
                                           input logic [2:0] rcw);
    ddr4_cmd_t c;
    if (cs_n) begin
      c = DES;
    end else if (!act_n) begin
      c = ACT;
    end else begin
      case (rcw)
        3'b000:  c = MRS;
        3'b001:  c = REF;
        3'b010:  c = PRE;
        3'b011:  c = RSV;
        3'b100:  c = WR;
        3'b101:  c = RD;
        3'b110:  c = ZQ;
        default: c = NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/ddr4_bank_ref_fsm.sv
// One bank's IDLE/ACTIVE/REFRESHING state machine with its refresh down-counter.
// Reports why a command aimed at this bank would be illegal; state changes only when go_i.
module ddr4_bank_ref_fsm
  import ddr4_cmd_pkg::*;
#(
  parameter int unsigned TRFC = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  ddr4_cmd_t  cmd_i,
  input  logic       hit_i,
  input  logic       all_i,
  input  logic       go_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       act_o,
  output ddr4_viol_t illegal_o
);

  localparam int unsigned CntW = $clog2(TRFC);
  localparam logic [CntW-1:0] CntInit = CntW'(TRFC - 1);

  bank_state_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            sel, refreshing, expiring;

  assign sel        = hit_i | all_i;
  assign refreshing = (state_q == StRefreshing);
  // A refresh on its final edge may be restarted by a new REF on that same edge
  assign expiring   = refreshing && (cnt_q == '0);

  always_comb begin
    illegal_o = V_NONE;
    if (sel) begin
      case (cmd_i)
        REF: begin
          if (state_q == StActive)       illegal_o = V_REF_OPEN;
          else if (refreshing && !expiring) illegal_o = V_REF_BUSY;
        end
        PRE: begin
          if (refreshing) illegal_o = V_REF_BUSY;
        end
        ACT: begin
          if (refreshing)                illegal_o = V_REF_BUSY;
          else if (state_q == StActive)  illegal_o = V_ACT_OPEN;
        end
        RD, WR: begin
          if (refreshing)                illegal_o = V_REF_BUSY;
          else if (state_q == StIdle)    illegal_o = V_NOT_OPEN;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = expiring;
    if (refreshing) begin
      if (expiring) state_d = StIdle;
      else          cnt_d   = cnt_q - 1'b1;
    end
    if (go_i && sel) begin
      case (cmd_i)
        REF: begin
          state_d = StRefreshing;
          cnt_d   = CntInit;
        end
        ACT: state_d = StActive;
        PRE: if (state_q == StActive) state_d = StIdle;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = refreshing;
  assign act_o  = (state_q == StActive);
  assign done_o = done_q;

endmodule

// File: rtl/ddr4_ref_responder.sv
// DIMM-side DDR4 command responder: decodes the command bus, tracks per-bank refresh state,
// flags illegal commands and counts accepted refreshes.
module ddr4_ref_responder
  import ddr4_cmd_pkg::*;
#(
  parameter int unsigned BGWIDTH   = 2,
  parameter int unsigned BAWIDTH   = 2,
  parameter int unsigned ADDRWIDTH = 17,
  parameter int unsigned TRFC      = 8,
  parameter int unsigned CNTWIDTH  = 16,
  localparam int unsigned NBANKS   = 2 ** (BGWIDTH + BAWIDTH)
) (
  input  logic                 ck_t,
  input  logic                 reset_n,
  input  logic                 cke,
  input  logic                 cs_n,
  input  logic                 act_n,
  input  logic [ADDRWIDTH-1:0] A,
  input  logic [BGWIDTH-1:0]   bg,
  input  logic [BAWIDTH-1:0]   ba,
  output logic [3:0]           cmd_o,
  output logic [NBANKS-1:0]    ref_busy,
  output logic [NBANKS-1:0]    ref_done,
  output logic [NBANKS-1:0]    bank_act,
  output logic                 viol,
  output logic [2:0]           viol_code,
  output logic [CNTWIDTH-1:0]  ref_cnt
);

  localparam int unsigned IdxW = BGWIDTH + BAWIDTH;

  ddr4_cmd_t             cmd_c, cmd_q;
  ddr4_viol_t            code_c, viol_code_q;
  logic                  viol_q, go, all_c;
  logic [IdxW-1:0]       idx;
  logic [CNTWIDTH-1:0]   ref_cnt_q;
  logic [NBANKS-1:0]     m_ref_open, m_ref_busy, m_not_open, m_act_open;
  ddr4_viol_t            bank_illegal [NBANKS];
  logic                  unused_addr;

  assign unused_addr = ^{A[13:11], A[9:0]};

  assign cmd_c = cke ? decode_cmd(cs_n, act_n, A[16:14]) : DES;
  assign idx   = {bg, ba};
  assign all_c = A[10] && ((cmd_c == REF) || (cmd_c == PRE));

  for (genvar k = 0; k < NBANKS; k++) begin : g_bank
    ddr4_bank_ref_fsm #(
      .TRFC (TRFC)
    ) u_bank (
      .clk_i     (ck_t),
      .rst_ni    (reset_n),
      .cmd_i     (cmd_c),
      .hit_i     (idx == IdxW'(k)),
      .all_i     (all_c),
      .go_i      (go),
      .busy_o    (ref_busy[k]),
      .done_o    (ref_done[k]),
      .act_o     (bank_act[k]),
      .illegal_o (bank_illegal[k])
    );
    assign m_ref_open[k] = (bank_illegal[k] == V_REF_OPEN);
    assign m_ref_busy[k] = (bank_illegal[k] == V_REF_BUSY);
    assign m_not_open[k] = (bank_illegal[k] == V_NOT_OPEN);
    assign m_act_open[k] = (bank_illegal[k] == V_ACT_OPEN);
  end

  // An open bank outranks a busy one for all-bank REF
  always_comb begin
    code_c = V_NONE;
    if (cmd_c == RSV)       code_c = V_RSV;
    else if (|m_ref_open)   code_c = V_REF_OPEN;
    else if (|m_ref_busy)   code_c = V_REF_BUSY;
    else if (|m_not_open)   code_c = V_NOT_OPEN;
    else if (|m_act_open)   code_c = V_ACT_OPEN;
  end

  assign go = (code_c == V_NONE);

  always_ff @(posedge ck_t or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q       <= DES;
      viol_q      <= 1'b0;
      viol_code_q <= V_NONE;
      ref_cnt_q   <= '0;
    end else begin
      cmd_q  <= cmd_c;
      viol_q <= !go;
      if (!go) viol_code_q <= code_c;
      if (go && (cmd_c == REF) && (ref_cnt_q != '1)) ref_cnt_q <= ref_cnt_q + 1'b1;
    end
  end

  assign cmd_o     = cmd_q;
  assign viol      = viol_q;
  assign viol_code = viol_code_q;
  assign ref_cnt   = ref_cnt_q;

endmodule

// File: tb/tb_ddr4_ref_responder.sv
// Scoreboard bench for ddr4_ref_responder: a time-based reference model pushes expected outputs
// per edge; a monitor pops and compares after each rising edge.
module tb_ddr4_ref_responder;
  import ddr4_cmd_pkg::*;

  localparam int NB   = 16;
  localparam int TRFC = 8;

  logic        ck_t = 1'b0;
  logic        reset_n = 1'b0;
  logic        cke = 1'b0, cs_n = 1'b1, act_n = 1'b1;
  logic [16:0] A = '0;
  logic [1:0]  bg = '0, ba = '0;

  logic [3:0]  cmd_o, cmd_o2;
  logic [15:0] ref_busy, ref_done, bank_act, busy2, done2, act2;
  logic        viol, viol2;
  logic [2:0]  viol_code, code2;
  logic [15:0] ref_cnt;
  logic [1:0]  ref_cnt2;

  ddr4_ref_responder #(.TRFC(TRFC), .CNTWIDTH(16)) dut (
    .ck_t(ck_t), .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .act_n(act_n), .A(A),
    .bg(bg), .ba(ba), .cmd_o(cmd_o), .ref_busy(ref_busy), .ref_done(ref_done),
    .bank_act(bank_act), .viol(viol), .viol_code(viol_code), .ref_cnt(ref_cnt)
  );

  ddr4_ref_responder #(.TRFC(TRFC), .CNTWIDTH(2)) dut_sat (
    .ck_t(ck_t), .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .act_n(act_n), .A(A),
    .bg(bg), .ba(ba), .cmd_o(cmd_o2), .ref_busy(busy2), .ref_done(done2),
    .bank_act(act2), .viol(viol2), .viol_code(code2), .ref_cnt(ref_cnt2)
  );

  always #5 ck_t = ~ck_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [15:0] busy, done, act;
    logic        viol;
    logic [2:0]  code;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a refresh is described by the edge index at which it ends
  int         tnow = 0;
  int         ref_end [NB];
  bit         open_b [NB];
  int         mcnt = 0;
  ddr4_viol_t held = V_NONE;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic ddr4_cmd_t ref_decode(input logic c_cs, input logic c_act,
                                           input logic [2:0] rcw);
    if (c_cs) return DES;
    if (!c_act) return ACT;
    case (rcw)
      3'd0: return MRS;
      3'd1: return REF;
      3'd2: return PRE;
      3'd3: return RSV;
      3'd4: return WR;
      3'd5: return RD;
      3'd6: return ZQ;
      default: return NOP;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NB; k++) begin
      ref_end[k] = -1;
      open_b[k]  = 0;
    end
    mcnt = 0;
    held = V_NONE;
  endtask

  task automatic model_step();
    exp_t       e;
    ddr4_cmd_t  c;
    ddr4_viol_t v;
    bit         a_open, a_refr, a_hold;
    logic [15:0] sel;
    tnow++;
    e = '0;
    if (!reset_n) begin
      model_clear();
      q.push_back(e);
      return;
    end
    c   = cke ? ref_decode(cs_n, act_n, A[16:14]) : DES;
    sel = '0;
    if (A[10] && (c == REF || c == PRE)) sel = '1;
    else sel[{bg, ba}] = 1'b1;
    a_open = 0; a_refr = 0; a_hold = 0;
    for (int k = 0; k < NB; k++) begin
      if (sel[k]) begin
        if (open_b[k]) a_open = 1;
        if (ref_end[k] >= tnow) a_refr = 1;
        if (ref_end[k] > tnow) a_hold = 1;
      end
    end
    v = V_NONE;
    case (c)
      REF:    if (a_open) v = V_REF_OPEN; else if (a_hold) v = V_REF_BUSY;
      PRE:    if (a_refr) v = V_REF_BUSY;
      ACT:    if (a_refr) v = V_REF_BUSY; else if (a_open) v = V_ACT_OPEN;
      RD, WR: if (a_refr) v = V_REF_BUSY; else if (!a_open) v = V_NOT_OPEN;
      RSV:    v = V_RSV;
      default: ;
    endcase
    for (int k = 0; k < NB; k++) e.done[k] = (ref_end[k] == tnow);
    if (v == V_NONE) begin
      for (int k = 0; k < NB; k++) begin
        if (sel[k]) begin
          if (c == REF) ref_end[k] = tnow + TRFC;
          if (c == ACT) open_b[k] = 1;
          if (c == PRE) open_b[k] = 0;
        end
      end
      if (c == REF) mcnt++;
    end else begin
      held = v;
    end
    for (int k = 0; k < NB; k++) begin
      e.busy[k] = (ref_end[k] > tnow);
      e.act[k]  = open_b[k];
    end
    e.cmd  = c;
    e.viol = (v != V_NONE);
    e.code = held;
    e.cnt  = (mcnt > 65535) ? 16'hFFFF : 16'(mcnt);
    e.cnt2 = (mcnt > 3) ? 2'd3 : 2'(mcnt);
    q.push_back(e);
  endtask

  // One command slot: drive away from the edge, predict, then the next edge samples it
  task automatic cyc(input logic rst, input logic c_cke, input logic c_cs, input logic c_act,
                     input logic [16:0] a, input logic [3:0] idx);
    bit fell;
    @(posedge ck_t);
    #3;
    fell    = reset_n && !rst;
    reset_n = rst;
    cke = c_cke; cs_n = c_cs; act_n = c_act; A = a; {bg, ba} = idx;
    model_step();
    if (fell) begin
      #1;
      chk("async_reset_busy", ref_busy, 0);
      chk("async_reset_done", ref_done, 0);
      chk("async_reset_cnt", ref_cnt, 0);
    end
  endtask

  function automatic logic [16:0] mk_a(input logic [2:0] rcw, input logic a10);
    logic [16:0] a;
    a = '0;
    a[16:14] = rcw;
    a[10] = a10;
    return a;
  endfunction

  task automatic cmd(input logic [2:0] rcw, input logic a10, input logic [3:0] idx);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, mk_a(rcw, a10), idx);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cmd(3'b111, 1'b0, 4'd0);
  endtask

  always @(posedge ck_t) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("cmd_o", cmd_o, e.cmd);
      chk("ref_busy", ref_busy, e.busy);
      chk("ref_done", ref_done, e.done);
      chk("bank_act", bank_act, e.act);
      chk("viol", viol, e.viol);
      chk("viol_code", viol_code, e.code);
      chk("ref_cnt", ref_cnt, e.cnt);
      chk("ref_cnt_sat", ref_cnt2, e.cnt2);
    end
  end

  initial begin
    model_clear();
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, '0, 4'd0);
    // Staggered per-bank REF across all 16 banks
    for (int k = 0; k < NB; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 17'b00100000000000001, 4'(k));
    nops(12);
    // All-bank REF
    cmd(3'b001, 1'b1, 4'd0);
    nops(10);
    // REF to an open bank, then close and refresh
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, 4'd5);
    cmd(3'b001, 1'b0, 4'd5);
    cmd(3'b010, 1'b0, 4'd5);
    cmd(3'b001, 1'b0, 4'd5);
    nops(10);
    // RD into refreshing bank, then REF on its final edge
    cmd(3'b001, 1'b0, 4'd3);
    nops(1);
    cmd(3'b101, 1'b0, 4'd3);
    nops(5);
    cmd(3'b001, 1'b0, 4'd3);
    nops(10);
    // cke low while the bus carries REF: nothing sampled, refresh still expires
    cmd(3'b001, 1'b0, 4'd2);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, mk_a(3'b001, 1'b0), 4'd2);
    // Reserved code and RD to an idle bank
    cmd(3'b011, 1'b0, 4'd0);
    cmd(3'b101, 1'b0, 4'd0);
    nops(2);
    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, $urandom_range(0, 15) != 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) != 0, mk_a(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0),
          4'($urandom_range(0, 15)));
    end
    nops(10);
    // Reset in the middle of an all-bank refresh
    cmd(3'b001, 1'b1, 4'd0);
    nops(3);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, mk_a(3'b111, 1'b0), 4'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, mk_a(3'b111, 1'b0), 4'd0);
    nops(4);
    cmd(3'b001, 1'b0, 4'd9);
    nops(10);
    @(posedge ck_t);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
